// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, computes the
// result up front and commits it after a fixed busy window.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_ok;

    logic        take_start;
    logic        is_div;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, divisor, uq, ur, sq, sr;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;

    assign start      = en & ~req & (op >= OP_MULT) & (op <= OP_DIVU);
    assign take_start = start & (state == IDLE);
    assign is_div     = (op == OP_DIV) | (op == OP_DIVU);
    assign busy       = (state == RUN);

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of hitting the overflow case of a native signed divide.
    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u  = {32'd0, a} * {32'd0, b};
    assign abs_a   = (op == OP_DIV && a[31]) ? (~a + 32'd1) : a;
    assign abs_b   = (op == OP_DIV && b[31]) ? (~b + 32'd1) : b;
    assign divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign uq      = abs_a / divisor;
    assign ur      = abs_a % divisor;
    assign sq      = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    assign sr      = a[31] ? (~ur + 32'd1) : ur;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b1;
        case (op)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = sr; res_lo = sq; res_ok = (b != 32'd0); end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; res_ok = (b != 32'd0); end
            default:  res_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take_start) state_next = RUN;
            RUN:     if (cnt == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (state == IDLE) begin
            if (take_start) begin
                cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_ok <= res_ok;
            end else if (en && !req && op == OP_MTHI) begin
                hi <= a;
            end else if (en && !req && op == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_ok) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (op == OP_MFHI) rd_data = hi;
        else if (op == OP_MFLO) rd_data = lo;
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: table of arithmetic vectors plus hand-written
// sequences for flush, reset, divide-by-zero and HI/LO moves.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset, en, req;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, rd_data;

    int tests = 0;
    int fails = 0;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .a(a), .b(b), .req(req),
        .start(start), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle instruction in E; checks the combinational start flag first.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic r, input logic exp_start);
        en = 1'b1; op = o; a = x; b = y; req = r;
        #1;
        check("start", 32'(start), 32'(exp_start));
        step();
        en = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
    endtask

    // Counts busy cycles from now until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[5] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};

        reset = 1'b1; en = 1'b0; req = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        step(); step();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1);
            wait_idle(n);
            check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Divide by zero keeps HI/LO after a full busy window
        issue(4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
        check("mthi_nobusy", 32'(busy), 32'd0);
        issue(4'd6, 32'h5678, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", hi, 32'h1234);
        check("mtlo_lo", lo, 32'h5678);
        issue(4'd4, 32'd99, 32'd0, 1'b0, 1'b1);
        wait_idle(n);
        check("div0_cycles", 32'(n), 32'd10);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'h5678);

        // Flushed MULT and flushed MTHI do nothing
        issue(4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
        check("flush_busy", 32'(busy), 32'd0);
        issue(4'd5, 32'hAAAA, 32'd0, 1'b1, 1'b0);
        step();
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h5678);

        // req during a running DIVU does not cancel it
        issue(4'd4, 32'd100, 32'd7, 1'b0, 1'b1);
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        wait_idle(n);
        check("req_run_cycles", 32'(n), 32'd8);
        check("req_run_hi", hi, 32'd2);
        check("req_run_lo", lo, 32'd14);

        // Illegal start and MTHI while RUN are ignored
        issue(4'd1, 32'd2, 32'd3, 1'b0, 1'b1);
        step();
        en = 1'b1; op = 4'd3; a = 32'd9; b = 32'd3;
        step();
        op = 4'd5; a = 32'hBAD0BAD0;
        step();
        en = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        wait_idle(n);
        check("ign_cycles", 32'(n), 32'd2);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd6);
        step();
        check("ign_no_restart", 32'(busy), 32'd0);

        // Reset in the 3rd busy cycle drops the pending result
        issue(4'd1, 32'd7, 32'd7, 1'b0, 1'b1);
        step(); step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("rst_late_busy", 32'(busy), 32'd0);
        check("rst_late_lo", lo, 32'd0);

        // Moves and reads
        issue(4'd6, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        check("mtlo_dead", lo, 32'hDEADBEEF);
        issue(4'd5, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
        en = 1'b1; op = 4'd8; #1;
        check("mflo_rd", rd_data, 32'hDEADBEEF);
        op = 4'd7; #1;
        check("mfhi_rd", rd_data, 32'hCAFEF00D);
        op = 4'd0; #1;
        check("none_rd", rd_data, 32'd0);
        check("none_start", 32'(start), 32'd0);
        op = 4'd12; #1;
        check("op12_rd", rd_data, 32'd0);
        check("op12_start", 32'(start), 32'd0);
        step();
        en = 1'b0; op = 4'd0;
        check("op12_hi", hi, 32'hCAFEF00D);
        check("op12_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu with fixed latencies.
- Handles mthi/mtlo writes and mfhi/mflo reads.
- Drives the `start` and `busy` flags that the hazard controller ORs to stall MDU-related instructions in D.
- Honours the exception/interrupt request so a flushed instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 2..15).
- DIV_CYCLES, 10, busy cycles for div/divu (range 2..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  a valid MDU instruction occupies E this cycle.
- op  input  4  encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9..15 treated as NONE.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- req  input  1  exception/interrupt flush; the instruction in E this cycle must have no architectural effect.
- start  output  1  combinational: en & ~req & (op in 1..4).
- busy  output  1  registered: high while a mult/div is in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.
- rd_data  output  32  combinational: hi when op==MFHI, lo when op==MFLO, else 0.

Behaviour:
- **Reset:** clears busy, the internal counter, the pending HI/LO result, hi and lo to 0. A reset mid-operation drops the pending result with no commit.
- **States:**
  - IDLE (busy=0).
  - RUN (busy=1, counter cnt 4 bits).
- **IDLE, start=1 at edge:**
  - Compute the full result combinationally from a/b and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises the cycle after start. start and busy are never both high in a legal program.
- **RUN:**
  - cnt decrements each edge.
  - At the edge where cnt==1: commit pend_hi/pend_lo to hi/lo, clear busy, return to IDLE.
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). The new hi/lo are visible in the first cycle busy is low.
- **Arithmetic:**
  - MULT: signed 32x32->64 multiply; hi = product[63:32], lo = product[31:0].
  - MULTU: unsigned 32x32->64 multiply, same split.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- **Divide by zero (b==0):** runs the full DIV_CYCLES with busy, then commits nothing; hi/lo unchanged.
- **MTHI/MTLO:** with en & ~req & IDLE, write a into hi/lo at the edge; no busy.
- **MTHI/MTLO with req=1:** no write.
- **MTHI/MTLO while busy:** ignored. The hazard controller stalls these, so this case is unreachable in a legal program.
- **MFHI/MFLO:** purely combinational read of the current hi/lo; no state change.
- **req=1 while IDLE:** no operation starts and start=0.
- **req=1 while RUN:** the in-flight operation belongs to an older, committed instruction, so it continues and commits normally.
- **start while RUN (illegal):** ignored; the counter and pending result are unaffected.
- **en=0 or op NONE:** no state change.

Test Plan:
- **Multiply latency:** reset, then MULT a=0xFFFFFFFE(-2) b=3 with en=1 for 1 cycle -> busy=1 for exactly 5 cycles; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **Unsigned multiply, signed divide:**
  - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - DIV a=-7 (0xFFFFFFF9) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Divide edge cases:**
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU with b=0 after MTHI 0x1234/MTLO 0x5678 -> busy 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- **Flush:**
  - MULT with req=1 in the same cycle -> start=0, busy stays 0, hi/lo unchanged.
  - req asserted 2 cycles into a running DIVU 100/7 -> still commits lo=14, hi=2.
- **Reset mid-operation:** reset pulsed in the 3rd busy cycle of a MULT -> next cycle busy=0, hi=lo=0, and no later commit appears.
- **Move to/from HI/LO:**
  - MTLO a=0xDEADBEEF -> lo updates at the next edge.
  - MFLO then gives rd_data=0xDEADBEEF.
  - MFHI gives rd_data=hi.
  - op=NONE gives rd_data=0.
